// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich core scheduler: fixed-point format,
// FSM state encoding and a signed compare helper.
package izh_pkg;

    localparam int N = 32;
    localparam int Q = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        APPLY,
        STORE,
        DONE
    } state_t;

    // Two's complement a >= b on raw fixed-point words.
    function automatic logic signed_ge(input logic [N-1:0] a, input logic [N-1:0] b);
        return $signed(a) >= $signed(b);
    endfunction

endpackage

// File: rtl/neuron_state_mem.sv
// Per-neuron voltage / recovery / input-current register arrays with a bulk
// load port, a write-back port for the scheduler and two read muxes.
module neuron_state_mem
    import izh_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W = $clog2(NUM_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_all,
    input  logic [N-1:0]     v_init,
    input  logic [N-1:0]     w_init,
    input  logic             cur_we,
    input  logic [IDX_W-1:0] cur_addr,
    input  logic [N-1:0]     cur_data,
    input  logic             st_we,
    input  logic [IDX_W-1:0] st_idx,
    input  logic [N-1:0]     st_v,
    input  logic [N-1:0]     st_w,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [N-1:0]     rd_v,
    output logic [N-1:0]     rd_w,
    output logic [N-1:0]     idx_v,
    output logic [N-1:0]     idx_w,
    output logic [N-1:0]     idx_cur
);

    logic [N-1:0] v_mem   [NUM_NEURONS];
    logic [N-1:0] w_mem   [NUM_NEURONS];
    logic [N-1:0] cur_mem [NUM_NEURONS];

    // Neuron state: bulk load on reset/init, otherwise single-entry write-back.
    always_ff @(posedge clk) begin
        if (rst || load_all) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_mem[i] <= v_init;
                w_mem[i] <= w_init;
            end
        end else if (st_we) begin
            v_mem[st_idx] <= st_v;
            w_mem[st_idx] <= st_w;
        end
    end

    // Input currents: cleared by reset, host-writable in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cur_mem[i] <= '0;
            end
        end else if (cur_we) begin
            cur_mem[cur_addr] <= cur_data;
        end
    end

    assign rd_v    = v_mem[rd_addr];
    assign rd_w    = w_mem[rd_addr];
    assign idx_v   = v_mem[st_idx];
    assign idx_w   = w_mem[st_idx];
    assign idx_cur = cur_mem[st_idx];

endmodule

// File: rtl/izhikevich_scheduler.sv
// Time-multiplexes one external izhikevich_core over NUM_NEURONS neurons,
// three cycles per neuron (LOAD, APPLY, STORE) plus one DONE cycle per frame.
//
// state | meaning
// IDLE  | waiting for start/init
// LOAD  | core_rst high, core loads v/w of neuron idx
// APPLY | core_apply high, core integrates with cur_mem[idx]
// STORE | write core result back, detect spike on pre-update voltage
// DONE  | done pulse, publish spike vector, count frame
module izhikevich_scheduler
    import izh_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   init,
    input  logic [N-1:0]           v_init,
    input  logic [N-1:0]           w_init,
    input  logic [N-1:0]           v_th,
    input  logic                   cur_we,
    input  logic [IDX_W-1:0]       cur_addr,
    input  logic [N-1:0]           cur_data,
    input  logic [IDX_W-1:0]       rd_addr,
    output logic [N-1:0]           rd_v,
    output logic [N-1:0]           rd_w,
    output logic                   busy,
    output logic                   done,
    output logic                   spike_valid,
    output logic [IDX_W-1:0]       spike_idx,
    output logic [NUM_NEURONS-1:0] spikes,
    output logic [N-1:0]           frame_count,
    output logic                   core_rst,
    output logic                   core_apply,
    output logic [N-1:0]           core_v_init,
    output logic [N-1:0]           core_w_init,
    output logic [N-1:0]           core_i,
    input  logic [N-1:0]           core_voltage,
    input  logic [N-1:0]           core_w
);

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [NUM_NEURONS-1:0] work_spikes;
    logic [NUM_NEURONS-1:0] spike_bit;
    logic [N-1:0]           idx_v;
    logic [N-1:0]           idx_cur;
    logic                   fire;
    logic                   load_all;
    logic                   st_we;

    assign load_all  = (state == IDLE) && init;
    assign st_we     = (state == STORE);
    // idx_v is still the pre-update voltage during STORE; write-back lands on the edge.
    assign fire      = signed_ge(idx_v, v_th);
    assign spike_bit = fire ? (NUM_NEURONS'(1) << idx) : '0;
    assign core_v_init = idx_v;

    neuron_state_mem #(
        .NUM_NEURONS(NUM_NEURONS),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .load_all(load_all),
        .v_init  (v_init),
        .w_init  (w_init),
        .cur_we  (cur_we),
        .cur_addr(cur_addr),
        .cur_data(cur_data),
        .st_we   (st_we),
        .st_idx  (idx),
        .st_v    (core_voltage),
        .st_w    (core_w),
        .rd_addr (rd_addr),
        .rd_v    (rd_v),
        .rd_w    (rd_w),
        .idx_v   (idx_v),
        .idx_w   (core_w_init),
        .idx_cur (idx_cur)
    );

    // Frame sequencer with registered core controls and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            spikes      <= '0;
            work_spikes <= '0;
            frame_count <= '0;
            core_rst    <= 1'b0;
            core_apply  <= 1'b0;
            core_i      <= '0;
        end else begin
            done        <= 1'b0;
            spike_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !init) begin
                        state       <= LOAD;
                        idx         <= '0;
                        busy        <= 1'b1;
                        work_spikes <= '0;
                        core_rst    <= 1'b1;
                    end
                end
                LOAD: begin
                    state      <= APPLY;
                    core_rst   <= 1'b0;
                    core_apply <= 1'b1;
                    core_i     <= idx_cur;
                end
                APPLY: begin
                    state      <= STORE;
                    core_apply <= 1'b0;
                end
                STORE: begin
                    if (fire) begin
                        spike_valid <= 1'b1;
                        spike_idx   <= idx;
                    end
                    work_spikes <= work_spikes | spike_bit;
                    if (idx == IDX_W'(NUM_NEURONS - 1)) begin
                        state       <= DONE;
                        idx         <= '0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        spikes      <= work_spikes | spike_bit;
                        frame_count <= frame_count + N'(1);
                    end else begin
                        state    <= LOAD;
                        idx      <= idx + IDX_W'(1);
                        core_rst <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
